// File: rtl/decode_stage_ctrl.sv
// Decode/execute pipeline register for the RV32I pipeline.
// It decodes the opcode into the control bundle, extracts the register fields,
// inserts one bubble on a load-use hazard, accepts flushes, and counts illegal
// opcodes with a saturating counter.
module decode_stage_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             Branch,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       J,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [XLEN-1:0]  pc_out,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Decoded view of the incoming instruction
  logic       dec_reg_write, dec_mem_write, dec_alu_src, dec_branch, dec_illegal;
  logic [2:0] dec_imm_src;
  logic [1:0] dec_result_src, dec_alu_op, dec_j;
  logic       uses_rs1, uses_rs2;

  // Held entry
  logic             valid_q;
  logic             reg_write_q, mem_write_q, alu_src_q, branch_q, illegal_q;
  logic [2:0]       imm_src_q;
  logic [1:0]       result_src_q, alu_op_q, j_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       funct3_q;
  logic             funct7b5_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic adv, hz, load_d, count_d;

  // Bits of instr that no decoded field depends on
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:25]};

  // Opcode decode table; unsupported opcodes drive all-zero controls
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_imm_src    = 3'b000;
    dec_result_src = 2'b00;
    dec_alu_op     = 2'b00;
    dec_j          = 2'b00;
    dec_illegal    = 1'b0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    case (instr[6:0])
      OP_LOAD: begin
        dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_result_src = 2'b01;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec_imm_src = 3'b001; dec_alu_src = 1'b1; dec_mem_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 2'b10;
        uses_rs1 = 1'b1;
      end
      OP_AUIPC: begin
        dec_reg_write = 1'b1; dec_imm_src = 3'b100; dec_alu_src = 1'b1;
        dec_alu_op = 2'b11;
      end
      OP_REG: begin
        dec_reg_write = 1'b1; dec_alu_op = 2'b10;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm_src = 3'b010; dec_branch = 1'b1; dec_alu_op = 2'b01;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec_reg_write = 1'b1; dec_imm_src = 3'b011; dec_result_src = 2'b10;
        dec_j = 2'b01;
      end
      OP_JALR: begin
        dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_result_src = 2'b10;
        dec_alu_op = 2'b10; dec_j = 2'b10;
        uses_rs1 = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Handshake, load-use hazard and illegal-counter next state
  always_comb begin
    adv = !valid_q || ex_ready;
    hz  = valid_q && (result_src_q == 2'b01) && (rd_q != 5'd0) && in_valid &&
          ((uses_rs1 && (instr[19:15] == rd_q)) ||
           (uses_rs2 && (instr[24:20] == rd_q)));
    // A flush overrides the hazard: the presented instruction is swallowed
    in_ready = adv && (flush || !hz);
    load_d   = adv && in_valid && !hz && !flush;
    count_d  = load_d && dec_illegal && (cnt_q != '1);
    cnt_d    = count_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Pipeline register and illegal counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
      imm_src_q    <= '0;
      result_src_q <= '0;
      alu_op_q     <= '0;
      j_q          <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      funct3_q     <= '0;
      funct7b5_q   <= 1'b0;
      pc_q         <= '0;
      cnt_q        <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_d) begin
        valid_q      <= 1'b1;
        reg_write_q  <= dec_reg_write;
        mem_write_q  <= dec_mem_write;
        alu_src_q    <= dec_alu_src;
        branch_q     <= dec_branch;
        illegal_q    <= dec_illegal;
        imm_src_q    <= dec_imm_src;
        result_src_q <= dec_result_src;
        alu_op_q     <= dec_alu_op;
        j_q          <= dec_j;
        rd_q         <= instr[11:7];
        rs1_q        <= instr[19:15];
        rs2_q        <= instr[24:20];
        funct3_q     <= instr[14:12];
        funct7b5_q   <= instr[30];
        pc_q         <= pc_in;
      end else if (adv) begin
        // Bubble, flush or empty slot: nothing valid may carry control
        valid_q      <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_write_q  <= 1'b0;
        alu_src_q    <= 1'b0;
        branch_q     <= 1'b0;
        illegal_q    <= 1'b0;
        imm_src_q    <= '0;
        result_src_q <= '0;
        alu_op_q     <= '0;
        j_q          <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = valid_q;
  assign RegWrite      = reg_write_q;
  assign MemWrite      = mem_write_q;
  assign ALUSrc        = alu_src_q;
  assign Branch        = branch_q;
  assign ImmSrc        = imm_src_q;
  assign ResultSrc     = result_src_q;
  assign ALUOp         = alu_op_q;
  assign J             = j_q;
  assign rd            = rd_q;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign funct3        = funct3_q;
  assign funct7b5      = funct7b5_q;
  assign pc_out        = pc_q;
  assign illegal       = illegal_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Bench for decode_stage_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked against a table-driven behavioural model.
module tb_decode_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, ex_ready, out_valid;
  logic [31:0] instr, pc_in, pc_out;
  logic        RegWrite, MemWrite, ALUSrc, Branch, funct7b5, illegal;
  logic [2:0]  ImmSrc, funct3;
  logic [1:0]  ResultSrc, ALUOp, J;
  logic [4:0]  rd, rs1, rs2;
  logic [7:0]  illegal_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  decode_stage_ctrl #(.XLEN(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .Branch(Branch), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .J(J), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7b5(funct7b5), .pc_out(pc_out), .illegal(illegal),
    .illegal_count(illegal_count)
  );

  wire [12:0] dut_ctl = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, J};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode table: {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, J}
  function automatic logic [12:0] ref_ctl(input logic [31:0] w);
    case (w[6:0])
      7'b0000011: return 13'b1_000_1_0_01_0_00_00;
      7'b0100011: return 13'b0_001_1_1_00_0_00_00;
      7'b0010011: return 13'b1_000_1_0_00_0_10_00;
      7'b0010111: return 13'b1_100_1_0_00_0_11_00;
      7'b0110011: return 13'b1_000_0_0_00_0_10_00;
      7'b1100011: return 13'b0_010_0_0_00_1_01_00;
      7'b1101111: return 13'b1_011_0_0_10_0_00_01;
      7'b1100111: return 13'b1_000_1_0_10_0_10_10;
      default:    return 13'b0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    return w[6:0] inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0010111,
                          7'b0110011, 7'b1100011, 7'b1101111, 7'b1100111};
  endfunction

  function automatic bit reads_rs1(input logic [31:0] w);
    return w[6:0] inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                          7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads_rs2(input logic [31:0] w);
    return w[6:0] inside {7'b0100011, 7'b0110011, 7'b1100011};
  endfunction

  // Model state: the instruction word the stage should be holding
  bit          m_v, m_bub;
  logic [31:0] m_ins, m_pc;
  int unsigned m_cnt;
  bit          run_chk = 1'b0;

  function automatic bit m_hazard();
    return m_v && (m_ins[6:0] == 7'b0000011) && (m_ins[11:7] != 5'd0) && in_valid &&
           ((reads_rs1(instr) && instr[19:15] == m_ins[11:7]) ||
            (reads_rs2(instr) && instr[24:20] == m_ins[11:7]));
  endfunction

  // Model update at each edge; async reset mirrors the DUT's
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v = 0; m_bub = 0; m_ins = '0; m_pc = '0; m_cnt = 0;
    end else begin
      bit hzv, advv;
      hzv  = m_hazard();
      advv = !m_v || ex_ready;
      if (advv && !flush && in_valid && !hzv) begin
        m_v = 1; m_bub = 0; m_ins = instr; m_pc = pc_in;
        if (!ref_legal(instr) && m_cnt < 255) m_cnt++;
      end else begin
        m_bub = advv && !flush && in_valid && hzv;
        if (advv || flush) m_v = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      chk("in_ready", in_ready, (!m_v || ex_ready) && (flush || !m_hazard()));
      chk("out_valid", out_valid, m_v);
      chk("illegal_count", illegal_count, m_cnt);
      if (m_v) begin
        chk("ctl", dut_ctl, ref_ctl(m_ins));
        chk("illegal", illegal, !ref_legal(m_ins));
        chk("fields", {rd, rs1, rs2, funct3, funct7b5},
            {m_ins[11:7], m_ins[19:15], m_ins[24:20], m_ins[14:12], m_ins[30]});
        chk("pc_out", pc_out, m_pc);
      end
      if (m_bub) begin
        chk("bubble_ctl", dut_ctl, 13'b0);
        chk("bubble_illegal", illegal, 1'b0);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic exr, input logic fl);
    @(posedge clk); #2;
    in_valid = iv; instr = ins; pc_in = pc; ex_ready = exr; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [12];
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0010111, 7'b0110011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'h7F, 7'h00, 7'h0F, 7'h73};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic random_phase(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
  endtask

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] ADD  = 32'h001080B3;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00028333;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] ADD0 = 32'h00000333;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] JAL  = 32'h000000EF;
  localparam logic [31:0] BEQ  = 32'h00208063;

  initial begin
    rst_n = 1'b0; in_valid = 0; instr = '0; pc_in = '0; ex_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", illegal_count, 8'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ctl", dut_ctl, 13'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    #1 rst_n = 1'b1;
    run_chk = 1'b1;

    // addi then add streamed back to back
    cyc(1, ADDI, 32'h100, 1, 0);
    cyc(1, ADD, 32'h104, 1, 0);
    #1;
    chk("addi_v", out_valid, 1'b1);
    chk("addi_ctl", {RegWrite, ALUSrc, ALUOp}, 4'b1_1_10);
    chk("addi_pc", pc_out, 32'h100);
    cyc(0, 0, 0, 1, 0);
    #1;
    chk("add_v", out_valid, 1'b1);
    chk("add_alusrc", ALUSrc, 1'b0);

    // load-use on x5: one stall, one bubble
    cyc(1, LW5, 32'h200, 1, 0);
    cyc(1, ADD6, 32'h204, 1, 0);
    #1 chk("lu_stall", in_ready, 1'b0);
    cyc(1, ADD6, 32'h204, 1, 0);
    #1;
    chk("lu_bubble", out_valid, 1'b0);
    chk("lu_ready", in_ready, 1'b1);
    cyc(0, 0, 0, 1, 0);
    #1;
    chk("lu_emit", {out_valid, rd}, {1'b1, 5'd6});

    // load to x0 never stalls
    cyc(1, LW0, 32'h300, 1, 0);
    cyc(1, ADD0, 32'h304, 1, 0);
    #1 chk("lu_x0", in_ready, 1'b1);

    // store held through three stall cycles
    cyc(1, SW, 32'h400, 1, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1, ADDI, 32'h404, 0, 0);
      #1;
      chk("sw_hold", {out_valid, MemWrite, ImmSrc, in_ready}, {1'b1, 1'b1, 3'b001, 1'b0});
      chk("sw_pc", pc_out, 32'h400);
    end
    cyc(0, 0, 0, 1, 0);

    // flush with a JAL held and a branch presented
    cyc(1, JAL, 32'h500, 1, 0);
    cyc(1, BEQ, 32'h504, 1, 1);
    #1 chk("fl_jal", {out_valid, J}, {1'b1, 2'b01});
    cyc(0, 0, 0, 1, 0);
    #1 chk("fl_drop", {out_valid, illegal_count}, {1'b0, 8'd0});

    // 300 illegal opcodes saturate the counter
    for (int unsigned i = 0; i < 300; i++)
      cyc(1, {$urandom_range(0, 32'h1FFFFFF), 7'h7F}, i, 1, 0);
    cyc(0, 0, 0, 1, 0);
    #1 chk("sat_count", illegal_count, 8'd255);

    random_phase(1500);

    // asynchronous reset with an entry held
    cyc(1, ADDI, 32'h600, 1, 0);
    @(posedge clk); #1;
    chk("pre_rst_v", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", out_valid, 1'b0);
    chk("arst_cnt", illegal_count, 8'd0);
    chk("arst_ctl", dut_ctl, 13'b0);
    chk("arst_pc", pc_out, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    random_phase(1500);
    cyc(0, 0, 0, 1, 0);
    @(posedge clk); @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
